uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 67 ++++++
 tb/tb_uart_rx.sv | 136 +++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled; in clk rst baud_tick rx, out rx_data rx_done frame_err rx_busy
module uart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state;
  logic        rx_m, rx_s, rx_prev;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  assign rx_busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      if (baud_tick) begin
        rx_prev <= rx_s;
        case (state)
          IDLE: if (rx_prev && !rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
          START: if (tick_cnt == 4'd7) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else tick_cnt <= tick_cnt + 4'd1;
          DATA: if (tick_cnt == 4'd15) begin
            tick_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= STOP;
            else bit_cnt <= bit_cnt + 3'd1;
          end else tick_cnt <= tick_cnt + 4'd1;
          STOP: if (tick_cnt == 4'd15) begin
            tick_cnt <= '0;
            state    <= IDLE;
            if (rx_s) begin
              rx_data <= shreg;
              rx_done <= 1'b1;
            end else frame_err <= 1'b1;
          end else tick_cnt <= tick_cnt + 4'd1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with directed 8N1 frames
`timescale 1ns/1ps
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, frame_err, rx_busy;
  typedef struct packed {logic err; logic [7:0] data;} ev_t;
  ev_t        q[$];
  int         tests = 0;
  int         fails = 0;
  int         tick_per = 4;
  int         tick_cnt = 0;
  int         busy_cyc = 0;
  logic [7:0] last = 8'h00;

  uart_rx dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick_cnt  = (tick_cnt + 1 >= tick_per) ? 0 : tick_cnt + 1;
    baud_tick = tick_cnt == 0;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rx_busy) busy_cyc++;
    if (!rst && (rx_done || frame_err)) begin
      ev_t e;
      chk("pulse_exclusive", int'(rx_done && frame_err), 0);
      if (q.size() == 0) chk("unexpected_event", {23'd0, frame_err, rx_data}, 32'h1ff);
      else begin
        e = q.pop_front();
        chk("event_kind", int'(frame_err), int'(e.err));
        chk("event_data", int'(rx_data), int'(e.data));
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!baud_tick);
    end
  endtask

  task automatic drive(input logic v, input int n);
    #1 rx = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int start_len, input int rst_bit);
    if (rst_bit < 0) begin
      q.push_back(stop ? {1'b0, d} : {1'b1, last});
      if (stop) last = d;
    end
    drive(1'b0, start_len);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        drive(d[i], 8);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("midrst_data", int'(rx_data), 0);
        chk("midrst_done", int'(rx_done), 0);
        chk("midrst_err", int'(frame_err), 0);
        chk("midrst_busy", int'(rx_busy), 0);
        rst  = 1'b0;
        last = 8'h00;
        wait_ticks(8);
      end else drive(d[i], 16);
    end
    drive(stop, 16);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", int'(rx_data), 0);
    chk("rst_done", int'(rx_done), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_busy", int'(rx_busy), 0);
    rst = 1'b0;
    tick_per = 16;
    wait_ticks(4);
    send_frame(8'h55, 1'b1, 16, -1);
    drive(1'b1, 4);
    chk("data_55", int'(rx_data), 'h55);
    tick_per = 4;
    wait_ticks(2);
    send_frame(8'hA5, 1'b1, 16, -1);
    send_frame(8'h3C, 1'b1, 16, -1);
    drive(1'b1, 4);
    chk("data_3c", int'(rx_data), 'h3C);
    tick_per = 2;
    wait_ticks(2);
    send_frame(8'hC3, 1'b1, 16, -1);
    drive(1'b1, 4);
    tick_per = 4;
    wait_ticks(2);
    busy_cyc = 0;
    drive(1'b0, 4);
    drive(1'b1, 20);
    chk("glitch_busy_cycles", busy_cyc, 8 * 4);
    send_frame(8'hFF, 1'b0, 16, -1);
    busy_cyc = 0;
    drive(1'b0, 40);
    chk("held_low_busy", busy_cyc, 0);
    drive(1'b1, 20);
    chk("ferr_keeps_data", int'(rx_data), 'hC3);
    send_frame(8'hFF, 1'b1, 16, 3);
    drive(1'b1, 20);
    chk("after_rst_data", int'(rx_data), 0);
    send_frame(8'h81, 1'b1, 16, -1);
    drive(1'b1, 4);
    send_frame(8'h96, 1'b1, 13, -1);
    drive(1'b1, 4);
    send_frame(8'h69, 1'b1, 19, -1);
    drive(1'b1, 40);
    chk("data_69", int'(rx_data), 'h69);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
